// File: rtl/fp_normalize_l.sv
// Two-stage significand normalizer: stage 1 captures the operand and its leading-zero
// count, stage 2 shifts left and adjusts the exponent, clamping at exponent zero.
module fp_normalize_l (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] mant_in,
   input  logic [4:0]  exp_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] mant_out,
   output logic [4:0]  exp_out,
   output logic        zero,
   output logic        underflow
);

   localparam int unsigned MW  = 16;
   localparam int unsigned EW  = 5;
   localparam int unsigned LZW = 5;

   typedef struct packed {
      logic [MW-1:0]  mant;
      logic [EW-1:0]  exp;
      logic [LZW-1:0] lz;
   } s1_t;

   typedef struct packed {
      logic [MW-1:0] mant;
      logic [EW-1:0] exp;
      logic          zero;
      logic          underflow;
   } s2_t;

   logic           s1_valid_q, s1_valid_d;
   logic           s2_valid_q, s2_valid_d;
   s1_t            s1_q, s1_d;
   s2_t            s2_q, s2_d;
   s2_t            res_c;
   logic [LZW-1:0] lz_c;
   logic [LZW-1:0] shamt_c;
   logic           clamp_c;
   logic           s2_load_c;
   logic           in_fire_c;

   // Leading-zero count of the incoming significand; all-zero input reads as MW.
   always_comb begin
      lz_c = LZW'(MW);
      for (int i = 0; i < int'(MW); i++) begin
         if (mant_in[i]) lz_c = LZW'(int'(MW) - 1 - i);
      end
   end

   // Shift is limited by the exponent so the result never drops below exponent zero.
   always_comb begin
      clamp_c = (s1_q.lz > s1_q.exp);
      shamt_c = clamp_c ? s1_q.exp : s1_q.lz;
      res_c   = '0;
      if (s1_q.mant == '0) begin
         res_c.zero = 1'b1;
      end else begin
         res_c.mant      = (shamt_c >= LZW'(MW)) ? '0 : (s1_q.mant << shamt_c);
         res_c.exp       = clamp_c ? '0 : (s1_q.exp - s1_q.lz);
         res_c.underflow = clamp_c;
      end
   end

   assign s2_load_c = !s2_valid_q || out_ready;
   assign in_ready  = !s1_valid_q || s2_load_c;
   assign in_fire_c = in_valid && in_ready;

   // Pipeline advance: a stage loads when empty or when its occupant moves on.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;
      if (in_fire_c) begin
         s1_valid_d = 1'b1;
         s1_d       = '{mant: mant_in, exp: exp_in, lz: lz_c};
      end else if (s2_load_c) begin
         s1_valid_d = 1'b0;
      end
      if (s2_load_c) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) s2_d = res_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign mant_out  = s2_q.mant;
   assign exp_out   = s2_q.exp;
   assign zero      = s2_q.zero;
   assign underflow = s2_q.underflow;

endmodule

// File: tb/tb_fp_normalize_l.sv
// Scoreboard bench for fp_normalize_l: expected results are queued at acceptance
// and compared in order as output beats are consumed.
module tb_fp_normalize_l;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] mant_in = '0;
   logic [4:0]  exp_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] mant_out;
   logic [4:0]  exp_out;
   logic        zero;
   logic        underflow;

   fp_normalize_l dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .mant_in(mant_in), .exp_in(exp_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .mant_out(mant_out), .exp_out(exp_out),
      .zero(zero), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] mant;
      logic [4:0]  exp;
      logic        zero;
      logic        uf;
      int          t;
   } exp_t;

   exp_t sb[$];
   int pass_cnt = 0;
   int total_cnt = 0;

   // Reference normalization written directly from the arithmetic definition.
   function automatic exp_t model(input logic [15:0] m, input logic [4:0] e);
      exp_t r;
      int   lz;
      lz = 0;
      while (lz < 16 && m[15-lz] == 1'b0) lz++;
      r.t = cyc;
      if (m == 16'h0) begin
         r.mant = '0; r.exp = '0; r.zero = 1'b1; r.uf = 1'b0;
      end else if (lz <= int'(e)) begin
         r.mant = m << lz; r.exp = 5'(int'(e) - lz); r.zero = 1'b0; r.uf = 1'b0;
      end else begin
         r.mant = m << e; r.exp = '0; r.zero = 1'b0; r.uf = 1'b1;
      end
      return r;
   endfunction

   task automatic drive(input logic v, input logic [15:0] m, input logic [4:0] e,
                        input logic ordy);
      @(negedge clk);
      in_valid = v; mant_in = m; exp_in = e; out_ready = ordy;
      #1;
   endtask

   task automatic test_reset;
      #2;
      total_cnt++;
      if ({out_valid, mant_out, exp_out, zero, underflow} !== 24'h0)
         $display("FAIL reset_outputs: got v=%b m=%h e=%0d z=%b u=%b, want all 0",
                  out_valid, mant_out, exp_out, zero, underflow);
      else pass_cnt++;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL post_reset: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      else pass_cnt++;
   endtask

   task automatic test_vectors;
      logic [15:0] dm[5] = '{16'h0010, 16'h8001, 16'h0000, 16'h0001, 16'h0100};
      logic [4:0]  de[5] = '{5'd20, 5'd3, 5'd17, 5'd4, 5'd7};
      exp_t        ex;
      logic [15:0] m;
      logic [4:0]  e;
      for (int k = 0; k < 27; k++) begin
         if (k < 5) begin
            m = dm[k]; e = de[k];
         end else begin
            m = 16'($urandom) >> $urandom_range(0, 16);
            e = 5'($urandom_range(0, 31));
         end
         drive(k < 17, m, e, 1'b1);
         if (out_valid && out_ready) begin
            total_cnt++;
            if (sb.size() == 0) $display("FAIL vec_extra_beat: got m=%h want none", mant_out);
            else begin
               ex = sb.pop_front();
               if ({mant_out, exp_out, zero, underflow} !== {ex.mant, ex.exp, ex.zero, ex.uf}
                   || cyc - ex.t != 2)
                  $display("FAIL vec_result: got m=%h e=%0d z=%b u=%b lat=%0d want m=%h e=%0d z=%b u=%b lat=2",
                           mant_out, exp_out, zero, underflow, cyc - ex.t,
                           ex.mant, ex.exp, ex.zero, ex.uf);
               else pass_cnt++;
            end
         end
         if (in_valid && in_ready) sb.push_back(model(mant_in, exp_in));
      end
      total_cnt++;
      if (sb.size() != 0) $display("FAIL vec_drain: got %0d pending want 0", sb.size());
      else pass_cnt++;
      sb.delete();
   endtask

   task automatic test_back_to_back;
      exp_t        ex;
      int          sent = 0;
      int          got = 0;
      logic        saw_stall = 1'b0;
      logic        hold = 1'b0;
      logic [26:0] held = '0;
      logic        exp_rdy;
      for (int k = 0; k < 30; k++) begin
         drive(sent < 5, 16'h0001 << (2 * sent + 1), 5'(10 + sent), !(k >= 3 && k <= 6));
         exp_rdy = (sb.size() < 2) || out_ready;
         total_cnt++;
         if (in_ready !== exp_rdy) $display("FAIL bp_in_ready: got %b want %b cycle %0d", in_ready, exp_rdy, k);
         else pass_cnt++;
         if (!in_ready) saw_stall = 1'b1;
         if (hold) begin
            total_cnt++;
            if ({out_valid, mant_out, exp_out, zero, underflow} !== held)
               $display("FAIL bp_hold: got %h want %h", {out_valid, mant_out, exp_out, zero, underflow}, held);
            else pass_cnt++;
         end
         hold = out_valid && !out_ready;
         held = {out_valid, mant_out, exp_out, zero, underflow};
         if (out_valid && out_ready) begin
            total_cnt++;
            got++;
            if (sb.size() == 0) $display("FAIL bp_extra_beat: got m=%h want none", mant_out);
            else begin
               ex = sb.pop_front();
               if ({mant_out, exp_out, zero, underflow} !== {ex.mant, ex.exp, ex.zero, ex.uf})
                  $display("FAIL bp_result: got m=%h e=%0d want m=%h e=%0d",
                           mant_out, exp_out, ex.mant, ex.exp);
               else pass_cnt++;
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(mant_in, exp_in));
            sent++;
         end
      end
      total_cnt++;
      if (!saw_stall || got != 5 || sb.size() != 0)
         $display("FAIL bp_summary: got stall=%b beats=%0d pending=%0d want stall=1 beats=5 pending=0",
                  saw_stall, got, sb.size());
      else pass_cnt++;
      sb.delete();
   endtask

   task automatic test_reset_mid;
      exp_t ex;
      int   waited = 0;
      drive(1'b1, 16'h0F00, 5'd9, 1'b1);
      drive(1'b1, 16'h00F0, 5'd9, 1'b1);
      drive(1'b0, 16'h0, 5'd0, 1'b0);
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL rst_mid_inflight: got v=%b want 1", out_valid);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL rst_mid_clear: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 16'h0, 5'd0, 1'b1);
         total_cnt++;
         if (out_valid !== 1'b0) $display("FAIL rst_mid_stale: got v=%b m=%h want v=0", out_valid, mant_out);
         else pass_cnt++;
      end
      drive(1'b1, 16'h0003, 5'd5, 1'b1);
      ex = model(mant_in, exp_in);
      drive(1'b0, 16'h0, 5'd0, 1'b1);
      while (!out_valid && waited < 6) begin
         drive(1'b0, 16'h0, 5'd0, 1'b1);
         waited++;
      end
      total_cnt++;
      if (!out_valid || {mant_out, exp_out, zero, underflow} !== {ex.mant, ex.exp, ex.zero, ex.uf})
         $display("FAIL rst_mid_first: got v=%b m=%h e=%0d u=%b want v=1 m=%h e=%0d u=%b",
                  out_valid, mant_out, exp_out, underflow, ex.mant, ex.exp, ex.uf);
      else pass_cnt++;
      drive(1'b0, 16'h0, 5'd0, 1'b1);
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_back_to_back;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
